// File: rtl/gf_pkg.sv
// Shared GF(2^M) definitions: field defaults, inverter FSM state codes and a
// width-generic GF multiply used by the datapath and by reference models.
package gf_pkg;

    localparam int unsigned GF_M    = 8;
    localparam logic [8:0]  GF_POLY = 9'h11D;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // MSB-first shift-and-add; operands and result live in the low m bits (m <= 16).
    function automatic logic [15:0] gf_mul(input logic [15:0] a, input logic [15:0] b,
                                           input int unsigned m, input logic [16:0] poly);
        logic [15:0] mask;
        logic [15:0] red;
        logic [15:0] p;
        mask = 16'hFFFF >> (16 - m);
        red  = poly[15:0] & mask;
        p    = '0;
        for (int i = 15; i >= 0; i--) begin
            if (i < int'(m)) begin
                p = ((p << 1) ^ (p[4'(m - 1)] ? red : 16'h0000)) & mask;
                if (b[4'(i)]) begin
                    p = p ^ a;
                end
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/gf_mult_comb.sv
// Combinational GF(2^M) multiplier, product reduced modulo POLY.
module gf_mult_comb
    import gf_pkg::*;
#(
    parameter int unsigned M    = GF_M,
    parameter logic [M:0]  POLY = GF_POLY
) (
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
    output logic [M-1:0] p
);

    assign p = M'(gf_mul(16'(a), 16'(b), M, 17'(POLY)));

endmodule

// File: rtl/gf_inv_seq.sv
// Sequential GF(2^M) inverter: y = x^(2^M-2) via M-1 square-and-multiply steps,
// valid/ready on both sides, zero operand flagged on out_zero.
module gf_inv_seq
    import gf_pkg::*;
#(
    parameter int unsigned M    = GF_M,
    parameter logic [M:0]  POLY = GF_POLY
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [M-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] out_data,
    output logic         out_zero
);

    localparam int unsigned     CW       = $clog2(M);
    localparam logic [CW-1:0]   CNT_LAST = CW'(M - 2);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [M-1:0]  sq_q, sq_d;
    logic [M-1:0]  acc_q, acc_d;
    logic          zero_q, zero_d;
    logic [M-1:0]  sq_sq;
    logic [M-1:0]  acc_mul;

    gf_mult_comb #(.M(M), .POLY(POLY)) u_square (
        .a (sq_q),
        .b (sq_q),
        .p (sq_sq)
    );

    // Multiply by the freshly squared value so acc tracks x^(2^(k+1)-2).
    gf_mult_comb #(.M(M), .POLY(POLY)) u_mult (
        .a (acc_q),
        .b (sq_sq),
        .p (acc_mul)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sq_d    = sq_q;
        acc_d   = acc_q;
        zero_d  = zero_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sq_d    = in_data;
                    acc_d   = M'(1);
                    cnt_d   = '0;
                    zero_d  = (in_data == '0);
                    state_d = CALC;
                end
            end
            CALC: begin
                sq_d  = sq_sq;
                acc_d = acc_mul;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sq_q    <= '0;
            acc_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sq_q    <= sq_d;
            acc_q   <= acc_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        out_data  = out_valid ? acc_q : '0;
        out_zero  = out_valid & zero_q;
    end

endmodule

// File: tb/tb_gf_inv_seq.sv
// Bench for gf_inv_seq: M=8/0x11D and M=4/0x13 instances checked against a
// polynomial-arithmetic reference with brute-force inverse search.
module tb_gf_inv_seq;

    logic clk;
    logic rst_n;

    logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_zero;
    logic [7:0] a_in_data, a_out_data;
    logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_zero;
    logic [3:0] b_in_data, b_out_data;

    int checks = 0;
    int passed = 0;

    gf_inv_seq #(.M(8), .POLY(9'h11D)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_data  (a_out_data),
        .out_zero  (a_out_zero)
    );

    gf_inv_seq #(.M(4), .POLY(5'h13)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .out_zero  (b_out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    // Reference: schoolbook carry-less product, then long division by poly.
    function automatic int ref_mul(int a, int b, int m, int poly);
        int p;
        p = 0;
        for (int i = 0; i < m; i++) if (((b >> i) & 1) == 1) p = p ^ (a << i);
        for (int i = 2 * m - 2; i >= m; i--) if (((p >> i) & 1) == 1) p = p ^ (poly << (i - m));
        return p;
    endfunction

    function automatic int ref_inv(int x, int m, int poly);
        if (x == 0) return 0;
        for (int y = 1; y < (1 << m); y++) if (ref_mul(x, y, m, poly) == 1) return y;
        return -1;
    endfunction

    function automatic logic f_in_ready(int sel);
        return (sel == 8) ? a_in_ready : b_in_ready;
    endfunction
    function automatic logic f_out_valid(int sel);
        return (sel == 8) ? a_out_valid : b_out_valid;
    endfunction
    function automatic logic [15:0] f_out_data(int sel);
        return (sel == 8) ? {8'h00, a_out_data} : {12'h000, b_out_data};
    endfunction
    function automatic logic f_out_zero(int sel);
        return (sel == 8) ? a_out_zero : b_out_zero;
    endfunction

    // One transaction. lat = edges from the accept edge to the edge at which
    // downstream first sees out_valid; held = result stable through the stall.
    task automatic do_op(input int sel, input int x, input int stall, output logic [15:0] y,
                         output logic z, output int lat, output bit held);
        int n;
        @(negedge clk);
        if (sel == 8) begin
            a_in_valid = 1'b1; a_in_data = x[7:0]; a_out_ready = (stall == 0);
        end else begin
            b_in_valid = 1'b1; b_in_data = x[3:0]; b_out_ready = (stall == 0);
        end
        n = 0;
        while (!f_in_ready(sel) && n < 40) begin @(negedge clk); n++; end
        @(negedge clk);
        if (sel == 8) begin a_in_valid = 1'b0; a_in_data = 8'($urandom); end
        else begin b_in_valid = 1'b0; b_in_data = 4'($urandom); end
        lat = 1;
        while (!f_out_valid(sel) && lat < 40) begin @(negedge clk); lat++; end
        y = f_out_data(sel);
        z = f_out_zero(sel);
        held = 1'b1;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            if (!f_out_valid(sel) || f_out_data(sel) !== y || f_out_zero(sel) !== z ||
                f_in_ready(sel)) held = 1'b0;
        end
        if (sel == 8) a_out_ready = 1'b1; else b_out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
        #12;
        checks++; if (a_out_valid !== 1'b0) $display("FAIL rst_valid8: got %b want 0", a_out_valid); else passed++;
        checks++; if (a_out_data !== 8'h00) $display("FAIL rst_data8: got %h want 00", a_out_data); else passed++;
        checks++; if (a_out_zero !== 1'b0) $display("FAIL rst_zero8: got %b want 0", a_out_zero); else passed++;
        checks++; if (b_out_valid !== 1'b0) $display("FAIL rst_valid4: got %b want 0", b_out_valid); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (a_in_ready !== 1'b1) $display("FAIL rst_ready8: got %b want 1", a_in_ready); else passed++;
        checks++; if (b_in_ready !== 1'b1) $display("FAIL rst_ready4: got %b want 1", b_in_ready); else passed++;
        checks++; if (a_out_valid !== 1'b0) $display("FAIL rst_rel_valid8: got %b want 0", a_out_valid); else passed++;
    endtask

    task automatic test_known8();
        logic [15:0] y; logic z; int lat; bit held;
        do_op(8, 8'h01, 0, y, z, lat, held);
        checks++; if (y !== 16'h01) $display("FAIL inv8_01: got %h want 01", y); else passed++;
        checks++; if (z !== 1'b0) $display("FAIL inv8_01_zero: got %b want 0", z); else passed++;
        checks++; if (lat != 8) $display("FAIL lat8: got %0d want 8", lat); else passed++;
        do_op(8, 8'h02, 0, y, z, lat, held);
        checks++; if (y !== 16'h8E) $display("FAIL inv8_02: got %h want 8e", y); else passed++;
        do_op(8, 8'h03, 0, y, z, lat, held);
        checks++; if (y !== 16'hF4) $display("FAIL inv8_03: got %h want f4", y); else passed++;
    endtask

    task automatic test_zero8();
        logic [15:0] y; logic z; int lat; bit held;
        do_op(8, 8'h00, 0, y, z, lat, held);
        checks++; if (y !== 16'h00) $display("FAIL zero8_data: got %h want 00", y); else passed++;
        checks++; if (z !== 1'b1) $display("FAIL zero8_flag: got %b want 1", z); else passed++;
        do_op(8, 8'h02, 0, y, z, lat, held);
        checks++; if (y !== 16'h8E) $display("FAIL zero8_next: got %h want 8e", y); else passed++;
        checks++; if (z !== 1'b0) $display("FAIL zero8_clr: got %b want 0", z); else passed++;
    endtask

    task automatic test_backpressure();
        int n;
        @(negedge clk);
        a_in_valid = 1'b1; a_in_data = 8'h03; a_out_ready = 1'b0;
        @(negedge clk);
        a_in_data = 8'h55;  // held high while busy: must be ignored
        n = 0;
        while (!a_out_valid && n < 40) begin @(negedge clk); n++; end
        checks++; if (a_out_valid !== 1'b1) $display("FAIL bp_valid: got %b want 1", a_out_valid); else passed++;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (a_out_valid !== 1'b1) $display("FAIL bp_hold_valid: got %b want 1", a_out_valid); else passed++;
            checks++; if (a_out_data !== 8'hF4) $display("FAIL bp_hold_data: got %h want f4", a_out_data); else passed++;
            checks++; if (a_in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b want 0", a_in_ready); else passed++;
        end
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        @(negedge clk);
        checks++; if (a_in_ready !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", a_in_ready); else passed++;
        checks++; if (a_out_valid !== 1'b0) $display("FAIL bp_release_valid: got %b want 0", a_out_valid); else passed++;
    endtask

    task automatic test_reset_mid();
        logic [15:0] y; logic z; int lat; bit held; bit seen;
        @(negedge clk);
        a_in_valid = 1'b1; a_in_data = 8'h02; a_out_ready = 1'b1;
        @(negedge clk);
        a_in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (a_out_valid !== 1'b0) $display("FAIL rmid_valid: got %b want 0", a_out_valid); else passed++;
        checks++; if (a_in_ready !== 1'b1) $display("FAIL rmid_ready: got %b want 1", a_in_ready); else passed++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin @(negedge clk); if (a_out_valid) seen = 1'b1; end
        checks++; if (seen !== 1'b0) $display("FAIL rmid_no_result: got %b want 0", seen); else passed++;
        do_op(8, 8'h03, 0, y, z, lat, held);
        checks++; if (y !== 16'hF4) $display("FAIL rmid_next: got %h want f4", y); else passed++;
    endtask

    task automatic test_m4();
        logic [15:0] y; logic z; int lat; bit held; int e;
        do_op(4, 4'h2, 0, y, z, lat, held);
        checks++; if (y !== 16'h9) $display("FAIL inv4_2: got %h want 9", y); else passed++;
        checks++; if (lat != 4) $display("FAIL lat4: got %0d want 4", lat); else passed++;
        do_op(4, 4'h0, 0, y, z, lat, held);
        checks++; if (y !== 16'h0) $display("FAIL zero4_data: got %h want 0", y); else passed++;
        checks++; if (z !== 1'b1) $display("FAIL zero4_flag: got %b want 1", z); else passed++;
        for (int x = 1; x < 16; x++) begin
            do_op(4, x, 0, y, z, lat, held);
            e = ref_inv(x, 4, 'h13);
            checks++; if (int'(y) != e || z !== 1'b0) $display("FAIL sweep4 x=%h: got %h/%b want %h/0", x, y, z, e); else passed++;
        end
    endtask

    task automatic test_sweep8();
        int perm [255];
        int j, t, e, x;
        logic [15:0] y; logic z; int lat; bit held;
        for (int i = 0; i < 255; i++) perm[i] = i + 1;
        for (int i = 254; i > 0; i--) begin
            j = int'($urandom_range(i, 0));
            t = perm[i]; perm[i] = perm[j]; perm[j] = t;
        end
        for (int i = 0; i < 255; i++) begin
            x = perm[i];
            do_op(8, x, 0, y, z, lat, held);
            e = ref_inv(x, 8, 'h11D);
            checks++; if (int'(y) != e || z !== 1'b0) $display("FAIL sweep8 x=%h: got %h/%b want %h/0", x, y, z, e); else passed++;
        end
    endtask

    task automatic test_random();
        int sel, m, poly, x, st, e;
        logic [15:0] y; logic z; int lat; bit held;
        for (int i = 0; i < 40; i++) begin
            sel  = ($urandom_range(1, 0) == 1) ? 8 : 4;
            m    = sel;
            poly = (sel == 8) ? 'h11D : 'h13;
            x    = int'($urandom_range((1 << m) - 1, 0));
            if (i % 8 == 0) x = 0;
            st   = int'($urandom_range(3, 0));
            do_op(sel, x, st, y, z, lat, held);
            e = ref_inv(x, m, poly);
            checks++;
            if (int'(y) != e || z !== (x == 0) || lat != m || !held)
                $display("FAIL rand M=%0d x=%h: got %h/%b lat %0d held %0d want %h/%b lat %0d held 1",
                         m, x, y, z, lat, held, e, (x == 0), m);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_known8();
        test_zero8();
        test_backpressure();
        test_reset_mid();
        test_m4();
        test_sweep8();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
